// File: rtl/video_lfsr_scrambler.sv
// Pixel-stream LFSR scrambler/descrambler. Active pixels (href=1) are XORed with
// an LFSR keystream; a requested seed takes effect at the next vsync rise.
// Latency: 1 cycle on o_data/o_href/o_vsync. No backpressure: one pixel per clk.
// Ports: clk, reset (sync, active-high), i_data/i_href/i_vsync pixel input,
//   seed_req (async level, rising edge arms), seed, o_data/o_href/o_vsync
//   delayed stream, locked (keystream active), frame_cnt (frames since seed load).
// Optional: define VIDEO_SCR_REKEY_EN to mix the frame count into each
//   per-frame reload value, giving a distinct keystream every frame.
module video_lfsr_scrambler #(
   parameter int DATA_W = 12,
   parameter int LFSR_W = 16,
   parameter logic [LFSR_W-1:0] TAPS = 16'h002D,
   parameter int FCNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_href,
   input  logic              i_vsync,
   input  logic              seed_req,
   input  logic [LFSR_W-1:0] seed,
   output logic [DATA_W-1:0] o_data,
   output logic              o_href,
   output logic              o_vsync,
   output logic              locked,
   output logic [FCNT_W-1:0] frame_cnt
);

   typedef enum logic [1:0] {IDLE, ARMED, RUN, RUN_PEND} state_t;

   localparam logic [LFSR_W-1:0] ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic              s1, s2, s3;
   logic              vsync_d;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] seed_reg;
   logic [LFSR_W-1:0] seed_fix;
   logic [LFSR_W-1:0] load_val;
   logic [LFSR_W-1:0] rekey_val;
   logic [DATA_W-1:0] key;
   logic              seed_rise, vs_rise, fb;
   logic              load, cnt_inc, cnt_clr;

   assign seed_rise = s2 & ~s3;
   assign vs_rise   = i_vsync & ~vsync_d;
   assign locked    = (state == RUN) || (state == RUN_PEND);
   assign fb        = ^(lfsr & TAPS);
   // An all-zero seed would lock the LFSR at zero forever.
   assign seed_fix  = (seed == '0) ? ONE : seed;

`ifdef VIDEO_SCR_REKEY_EN
   logic [FCNT_W-1:0] fcnt_nxt;
   logic [LFSR_W-1:0] rekey_raw;
   assign fcnt_nxt  = frame_cnt + 1'b1;
   assign rekey_raw = seed_reg ^ LFSR_W'(fcnt_nxt);
   assign rekey_val = (rekey_raw == '0) ? ONE : rekey_raw;
`else
   assign rekey_val = seed_reg;
`endif

   // A seed edge always wins over a coincident vsync edge: the seed is captured
   // and the load waits for the following frame boundary.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_val  = seed_reg;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (seed_rise) state_nxt = ARMED;
         end
         ARMED, RUN_PEND: begin
            if (vs_rise && !seed_rise) begin
               state_nxt = RUN;
               load      = 1'b1;
               cnt_clr   = 1'b1;
            end
         end
         RUN: begin
            if (seed_rise) begin
               state_nxt = RUN_PEND;
               cnt_inc   = vs_rise;
            end else if (vs_rise) begin
               load     = 1'b1;
               load_val = rekey_val;
               cnt_inc  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A load in the same cycle as an active pixel keys that pixel with the new value.
   assign key = load ? load_val[DATA_W-1:0] : lfsr[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         vsync_d   <= 1'b0;
         lfsr      <= '0;
         seed_reg  <= '0;
         frame_cnt <= '0;
         o_data    <= '0;
         o_href    <= 1'b0;
         o_vsync   <= 1'b0;
      end else begin
         state   <= state_nxt;
         s1      <= seed_req;
         s2      <= s1;
         s3      <= s2;
         vsync_d <= i_vsync;
         if (seed_rise) seed_reg <= seed_fix;
         if (load) lfsr <= load_val;
         else if (locked && i_href) lfsr <= {fb, lfsr[LFSR_W-1:1]};
         if (cnt_clr) frame_cnt <= '0;
         else if (cnt_inc) frame_cnt <= frame_cnt + 1'b1;
         o_href  <= i_href;
         o_vsync <= i_vsync;
         if (i_href) o_data <= locked ? (i_data ^ key) : i_data;
         else o_data <= '0;
      end
   end

endmodule

// File: tb/tb_video_lfsr_scrambler.sv
// Bench for video_lfsr_scrambler: random pixel frames against an event-level
// reference model, plus a TX->RX loopback pair sharing seed controls.
// Latency checked: outputs compared 1 ns after each rising edge.
module tb_video_lfsr_scrambler;

   localparam bit REKEY =
`ifdef VIDEO_SCR_REKEY_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] i_data = '0;
   logic        i_href = 1'b0;
   logic        i_vsync = 1'b0;
   logic        seed_req = 1'b0;
   logic [15:0] seed = '0;
   logic [11:0] o_data, rx_o_data;
   logic        o_href, o_vsync, locked, rx_o_href, rx_o_vsync, rx_locked;
   logic [7:0]  frame_cnt, rx_frame_cnt;

   always #5 clk = ~clk;

   video_lfsr_scrambler dut (
      .clk(clk), .reset(reset), .i_data(i_data), .i_href(i_href), .i_vsync(i_vsync),
      .seed_req(seed_req), .seed(seed), .o_data(o_data), .o_href(o_href),
      .o_vsync(o_vsync), .locked(locked), .frame_cnt(frame_cnt)
   );

   video_lfsr_scrambler rx (
      .clk(clk), .reset(reset), .i_data(o_data), .i_href(o_href), .i_vsync(o_vsync),
      .seed_req(seed_req), .seed(seed), .o_data(rx_o_data), .o_href(rx_o_href),
      .o_vsync(rx_o_vsync), .locked(rx_locked), .frame_cnt(rx_frame_cnt)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: keystream state plus the seed/frame bookkeeping.
   logic [15:0] m_lfsr, m_seed;
   logic [7:0]  m_fcnt;
   bit          m_locked, m_pending, m_vs_prev;
   bit          m_sr [3];

   // Loopback bookkeeping.
   bit          lb_en = 0;
   logic [11:0] lb_q [$];
   logic [11:0] lb_key [3][16];
   int          lb_frame = 0;
   int          lb_px = 0;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {^(v & 16'h002D), v[15:1]};
   endfunction

   function automatic logic [15:0] nonzero(input logic [15:0] v);
      return (v == 16'h0) ? 16'h0001 : v;
   endfunction

   task automatic model_reset();
      m_lfsr = '0; m_seed = '0; m_fcnt = '0;
      m_locked = 0; m_pending = 0; m_vs_prev = 0;
      for (int i = 0; i < 3; i++) m_sr[i] = 0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      seed_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         i_href = 1'($urandom);
         i_vsync = 1'($urandom);
         i_data = 12'($urandom);
         @(posedge clk); #1;
         check("rst_o_data", o_data, 0);
         check("rst_o_href", o_href, 0);
         check("rst_o_vsync", o_vsync, 0);
         check("rst_locked", locked, 0);
         check("rst_frame_cnt", frame_cnt, 0);
      end
      model_reset();
      reset = 1'b0;
      i_href = 1'b0;
      i_vsync = 1'b0;
      i_data = '0;
   endtask

   // One pixel clock: drive, predict, step, compare.
   task automatic drive(input bit href, input bit vs, input logic [11:0] d);
      logic [11:0] exp_d;
      bit sr_ev, vs_ev;
      i_href = href; i_vsync = vs; i_data = d;
      exp_d = '0;
      if (href) begin
         exp_d = m_locked ? (d ^ m_lfsr[11:0]) : d;
         if (m_locked) m_lfsr = lfsr_next(m_lfsr);
      end
      sr_ev = m_sr[1] && !m_sr[2];
      vs_ev = vs && !m_vs_prev;
      m_sr[2] = m_sr[1]; m_sr[1] = m_sr[0]; m_sr[0] = seed_req;
      m_vs_prev = vs;
      if (sr_ev) begin
         m_seed = nonzero(seed);
         m_pending = 1;
         if (m_locked && vs_ev) m_fcnt = m_fcnt + 8'd1;
      end else if (vs_ev) begin
         if (m_pending) begin
            m_lfsr = m_seed; m_fcnt = '0; m_locked = 1; m_pending = 0;
         end else if (m_locked) begin
            m_fcnt = m_fcnt + 8'd1;
            m_lfsr = REKEY ? nonzero(m_seed ^ {8'h00, m_fcnt}) : m_seed;
         end
      end
      @(posedge clk); #1;
      check("o_data", o_data, exp_d);
      check("o_href", o_href, href);
      check("o_vsync", o_vsync, vs);
      check("locked", locked, m_locked);
      check("frame_cnt", frame_cnt, m_fcnt);
      if (lb_en) begin
         if (rx_o_href) begin
            if (lb_q.size() == 0) check("lb_queue_empty", 1, 0);
            else check("lb_rx_data", rx_o_data, lb_q.pop_front());
         end
         if (href) begin
            lb_q.push_back(d);
            if (lb_px < 16) lb_key[lb_frame][lb_px] = o_data ^ d;
            lb_px++;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, i_vsync, '0);
   endtask

   task automatic arm(input logic [15:0] s);
      seed = s;
      seed_req = 1'b1;
      idle(4);
      seed_req = 1'b0;
      idle(4);
   endtask

   task automatic vsync_pulse();
      drive(0, 1, '0);
      drive(0, 1, '0);
      drive(0, 0, '0);
      drive(0, 0, '0);
   endtask

   // dense=1: href high for the whole line; otherwise random holes.
   // zero=1: all-zero pixels, so o_data exposes the keystream.
   task automatic frame(input int nlines, input int len, input bit dense, input bit zero);
      vsync_pulse();
      for (int l = 0; l < nlines; l++) begin
         for (int p = 0; p < len; p++)
            drive(dense ? 1'b1 : ($urandom_range(0, 3) != 0), 0, zero ? 12'h000 : 12'($urandom));
         idle(4);
      end
   endtask

   initial begin
      model_reset();
      // 1: reset with toggling inputs
      do_reset(3);

      // 2: IDLE bypass
      drive(1, 0, 12'hABC);
      check("t2_bypass", o_data, 12'hABC);
      drive(0, 0, 12'hABC);
      check("t2_blank", o_data, 12'h000);

      // 3: seed 0001, first keys 0001/8000/4000
      arm(16'h0001);
      drive(0, 1, '0);
      check("t3_locked_after_vs", locked, 1);
      drive(0, 0, '0);
      drive(1, 0, 12'hFFF); check("t3_px0", o_data, 12'hFFE);
      drive(1, 0, 12'hFFF); check("t3_px1", o_data, 12'hFFF);
      drive(1, 0, 12'hFFF); check("t3_px2", o_data, 12'hFFF);
      idle(3);

      // 5: zero seed, then mid-frame reseed to 00FF
      do_reset(1);
      arm(16'h0000);
      drive(0, 1, '0);
      drive(0, 0, '0);
      drive(1, 0, 12'h000); check("t5_zero_seed_key", o_data, 12'h001);
      for (int p = 0; p < 20; p++) drive(1, 0, 12'h000);
      arm(16'h00FF);
      check("t5_still_locked", locked, 1);
      for (int p = 0; p < 20; p++) drive(1, 0, 12'h000);
      frame(1, 8, 1, 1);
      check("t5_fcnt_reload", frame_cnt, 0);

      // 6: seed edge coincident with vsync edge while ARMED
      do_reset(1);
      arm(16'h0042);
      seed = 16'h0BCD;
      seed_req = 1'b1;
      drive(0, 0, '0);
      drive(0, 0, '0);
      drive(0, 1, '0);
      check("t6_stays_armed", locked, 0);
      drive(0, 1, '0);
      seed_req = 1'b0;
      idle(3);
      drive(0, 0, '0);
      drive(0, 1, '0);
      drive(0, 0, '0);
      drive(1, 0, 12'h000); check("t6_new_seed_key", o_data, 12'hBCD);
      idle(2);

      // Reset mid-frame
      frame(1, 10, 0, 0);
      drive(1, 0, 12'h5A5);
      do_reset(1);
      idle(2);

      // Randomized sessions with mid-frame reseeds
      for (int it = 0; it < 6; it++) begin
         do_reset(1);
         arm(16'($urandom));
         for (int f = 0; f < int'($urandom_range(2, 4)); f++) begin
            frame($urandom_range(1, 4), $urandom_range(5, 40), 0, 0);
            if ($urandom_range(0, 2) == 0) arm(16'($urandom));
         end
      end

      // 4: TX->RX loopback, 3 frames of 4x640
      do_reset(2);
      lb_q.delete();
      lb_en = 1;
      arm(16'h1234);
      for (int f = 0; f < 3; f++) begin
         lb_frame = f;
         lb_px = 0;
         frame(4, 640, 1, 0);
      end
      check("t4_fcnt_after_3", frame_cnt, 2);
      idle(3);
      check("t4_queue_drained", lb_q.size(), 0);
      lb_en = 0;
      begin
         bit diff;
         diff = 0;
         for (int i = 0; i < 16; i++)
            if (lb_key[0][i] != lb_key[1][i]) diff = 1;
         check("t4_rekey_differs", diff, REKEY);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
